// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and slot geometry for the dual TDM demux
package tdm_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int SLOT_W = 2;
  localparam int NUM_SLOTS = 4;
endpackage

// File: rtl/dual_tdm_demux_if.sv
// dual_tdm_demux_if: select/serial/parallel pins between the selector pair and the demux
interface dual_tdm_demux_if;
  logic       RUN;
  logic [1:0] EN_n;
  logic       Y1;
  logic       Y2;
  logic       A;
  logic       B;
  logic [3:0] Q1;
  logic [3:0] Q2;
  logic       VALID1;
  logic       VALID2;
  modport master (output RUN, EN_n, Y1, Y2, input A, B, Q1, Q2, VALID1, VALID2);
  modport slave (input RUN, EN_n, Y1, Y2, output A, B, Q1, Q2, VALID1, VALID2);
endinterface

// File: rtl/tdm_slot_timer.sv
// tdm_slot_timer: dwell and slot counters with sample and frame-end strobes
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_run,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_sample,
  output logic              o_frame_end
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [CW-1:0]     r_cnt;
  logic [SLOT_W-1:0] r_slot;
  assign o_slot      = r_slot;
  assign o_sample    = i_run && r_cnt == CW'(DWELL - 1);
  assign o_frame_end = o_sample && r_slot == SLOT_W'(NUM_SLOTS - 1);
  // count dwell cycles; the slot advances (mod 4) on each sample edge
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt  <= '0;
      r_slot <= '0;
    end else if (i_run) begin
      r_cnt  <= o_sample ? '0 : r_cnt + 1'b1;
      r_slot <= o_sample ? r_slot + 1'b1 : r_slot;
    end
  end
endmodule

// File: rtl/dual_tdm_demux.sv
// dual_tdm_demux: scans selector slots, rebuilds two 4-bit words (DUAL_TDM_DEMUX_HOLD_EN holds disabled Q)
module dual_tdm_demux
  import tdm_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic           CLK,
  input  logic           RST,
  dual_tdm_demux_if.slave bus
);
  state_t            r_state;
  state_t            w_next;
  logic [SLOT_W-1:0] w_slot;
  logic              w_sample;
  logic              w_frame_end;
  logic              w_run;
  logic              w_clear;
  logic [2:0]        r_sh1;
  logic [2:0]        r_sh2;
  logic [3:0]        r_q1;
  logic [3:0]        r_q2;
  logic              r_v1;
  logic              r_v2;
  logic [3:0]        w_off1;
  logic [3:0]        w_off2;
  assign w_run   = r_state == SCAN;
  assign w_clear = !(w_run && bus.RUN);
`ifdef DUAL_TDM_DEMUX_HOLD_EN
  assign w_off1 = r_q1;
  assign w_off2 = r_q2;
`else
  assign w_off1 = '0;
  assign w_off2 = '0;
`endif
  tdm_slot_timer #(.DWELL(DWELL)) u_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clear    (w_clear),
    .i_run      (w_run),
    .o_slot     (w_slot),
    .o_sample   (w_sample),
    .o_frame_end(w_frame_end)
  );
  // state register
  always_ff @(posedge CLK) begin
    r_state <= RST ? IDLE : w_next;
  end
  // RUN alone decides: enter/continue scanning, or abort/stop after a frame
  always_comb begin
    w_next = r_state;
    w_next = bus.RUN ? SCAN : IDLE;
  end
  // capture slots 0..2; slot 3 goes straight into the published word
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sh1 <= '0;
      r_sh2 <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS - 1; k++) begin
        if (w_sample && w_slot == SLOT_W'(k)) begin
          r_sh1[k] <= bus.Y1;
          r_sh2[k] <= bus.Y2;
        end
      end
    end
  end
  // publish at frame end, gated by the enables sampled at that edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q1 <= '0;
      r_q2 <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_frame_end && !bus.EN_n[0];
      r_v2 <= w_frame_end && !bus.EN_n[1];
      if (w_frame_end) begin
        r_q1 <= !bus.EN_n[0] ? {bus.Y1, r_sh1} : w_off1;
        r_q2 <= !bus.EN_n[1] ? {bus.Y2, r_sh2} : w_off2;
      end
    end
  end
  assign bus.A      = w_slot[0];
  assign bus.B      = w_slot[1];
  assign bus.Q1     = r_q1;
  assign bus.Q2     = r_q2;
  assign bus.VALID1 = r_v1;
  assign bus.VALID2 = r_v2;
endmodule
